// File: rtl/biu_arbiter2.sv
// Round-robin arbiter sharing one BIU between the data (p0) and instruction (p1) ports.
// Request mux and response routing are combinational; an owner FIFO steers per-beat responses.
module biu_arbiter2 #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = DATA_SIZE
) (
  input  logic                 HRESETn,
  input  logic                 HCLK,

  input  logic                 p0_stb_i,
  input  logic [ADDR_SIZE-1:0] p0_adri_i,
  input  logic [2:0]           p0_size_i,
  input  logic [2:0]           p0_type_i,
  input  logic [2:0]           p0_prot_i,
  input  logic                 p0_lock_i,
  input  logic                 p0_we_i,
  input  logic [DATA_SIZE-1:0] p0_d_i,
  output logic                 p0_stb_ack_o,
  output logic                 p0_d_ack_o,
  output logic                 p0_ack_o,
  output logic                 p0_err_o,
  output logic [DATA_SIZE-1:0] p0_q_o,
  output logic [ADDR_SIZE-1:0] p0_adro_o,

  input  logic                 p1_stb_i,
  input  logic [ADDR_SIZE-1:0] p1_adri_i,
  input  logic [2:0]           p1_size_i,
  input  logic [2:0]           p1_type_i,
  input  logic [2:0]           p1_prot_i,
  input  logic                 p1_lock_i,
  input  logic                 p1_we_i,
  input  logic [DATA_SIZE-1:0] p1_d_i,
  output logic                 p1_stb_ack_o,
  output logic                 p1_d_ack_o,
  output logic                 p1_ack_o,
  output logic                 p1_err_o,
  output logic [DATA_SIZE-1:0] p1_q_o,
  output logic [ADDR_SIZE-1:0] p1_adro_o,

  output logic                 biu_stb_o,
  output logic [ADDR_SIZE-1:0] biu_adri_o,
  output logic [2:0]           biu_size_o,
  output logic [2:0]           biu_type_o,
  output logic [2:0]           biu_prot_o,
  output logic                 biu_lock_o,
  output logic                 biu_we_o,
  output logic [DATA_SIZE-1:0] biu_d_o,
  input  logic                 biu_stb_ack_i,
  input  logic                 biu_d_ack_i,
  input  logic                 biu_ack_i,
  input  logic                 biu_err_i,
  input  logic [DATA_SIZE-1:0] biu_q_i,
  input  logic [ADDR_SIZE-1:0] biu_adro_i
);

  logic            sel_q, sel_d, last_q, last_d, lock_q, lock_d;
  logic            sel;
  logic [3:0]      own_q, own_d;
  logic [3:0][3:0] len_q, len_d;
  logic [1:0]      wptr_q, wptr_d, dptr_q, dptr_d, aptr_q, aptr_d;
  logic [3:0]      dcnt_q, dcnt_d, acnt_q, acnt_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            fifo_full, fifo_empty, push, pop, rsp_ok;
  logic            dack_v, ack_v, err_v, d_own, a_own, d_last, a_last;
  logic [3:0]      push_len;

  function automatic logic [3:0] beats_m1(input logic [2:0] t);
    case (t[2:1])
      2'b00:   beats_m1 = 4'd0;
      2'b01:   beats_m1 = 4'd3;
      2'b10:   beats_m1 = 4'd7;
      default: beats_m1 = 4'd15;
    endcase
  endfunction

  // Selection is frozen while a strobe is waiting for its acknowledge.
  always_comb begin
    sel = sel_q;
    if (!lock_q) begin
      if (p0_stb_i && !p1_stb_i)      sel = 1'b0;
      else if (p1_stb_i && !p0_stb_i) sel = 1'b1;
      else if (p0_stb_i && p1_stb_i)  sel = ~last_q;
    end
  end

  assign fifo_full  = cnt_q[2];
  assign fifo_empty = (cnt_q == 3'd0);

  assign biu_stb_o  = HRESETn & (sel ? p1_stb_i : p0_stb_i) & ~fifo_full;
  assign biu_adri_o = sel ? p1_adri_i : p0_adri_i;
  assign biu_size_o = sel ? p1_size_i : p0_size_i;
  assign biu_type_o = sel ? p1_type_i : p0_type_i;
  assign biu_prot_o = sel ? p1_prot_i : p0_prot_i;
  assign biu_lock_o = sel ? p1_lock_i : p0_lock_i;
  assign biu_we_o   = sel ? p1_we_i   : p0_we_i;
  // Write data follows the d_ack owner, which may lag the current grant.
  assign biu_d_o    = d_own ? p1_d_i : p0_d_i;

  assign push     = HRESETn & biu_stb_ack_i & ~fifo_full;
  assign push_len = beats_m1(biu_type_o);
  assign rsp_ok   = HRESETn & ~fifo_empty;
  assign err_v    = rsp_ok & biu_err_i;
  assign dack_v   = rsp_ok & biu_d_ack_i & ~biu_err_i;
  assign ack_v    = rsp_ok & biu_ack_i & ~biu_err_i;
  assign d_own    = own_q[dptr_q];
  assign a_own    = own_q[aptr_q];
  assign d_last   = (dcnt_q == len_q[dptr_q]);
  assign a_last   = (acnt_q == len_q[aptr_q]);
  assign pop      = ack_v & a_last;

  assign p0_stb_ack_o = HRESETn & biu_stb_ack_i & ~sel;
  assign p1_stb_ack_o = HRESETn & biu_stb_ack_i &  sel;
  assign p0_d_ack_o   = dack_v & ~d_own;
  assign p1_d_ack_o   = dack_v &  d_own;
  assign p0_ack_o     = ack_v  & ~a_own;
  assign p1_ack_o     = ack_v  &  a_own;
  assign p0_err_o     = err_v  & ~a_own;
  assign p1_err_o     = err_v  &  a_own;
  assign p0_q_o       = biu_q_i;
  assign p1_q_o       = biu_q_i;
  assign p0_adro_o    = biu_adro_i;
  assign p1_adro_o    = biu_adro_i;

  always_comb begin
    sel_d  = sel;
    last_d = push ? sel : last_q;
    lock_d = biu_stb_ack_i ? 1'b0 : (biu_stb_o ? 1'b1 : lock_q);
    own_d  = own_q;
    len_d  = len_q;
    wptr_d = wptr_q;
    dptr_d = dptr_q;
    aptr_d = aptr_q;
    dcnt_d = dcnt_q;
    acnt_d = acnt_q;
    cnt_d  = cnt_q;
    if (err_v) begin
      // Flush; a transfer accepted in the same cycle still gets tracked.
      wptr_d = 2'd0;
      dptr_d = 2'd0;
      aptr_d = 2'd0;
      dcnt_d = 4'd0;
      acnt_d = 4'd0;
      cnt_d  = 3'd0;
      if (push) begin
        own_d[0] = sel;
        len_d[0] = push_len;
        wptr_d   = 2'd1;
        cnt_d    = 3'd1;
      end
    end else begin
      if (push) begin
        own_d[wptr_q] = sel;
        len_d[wptr_q] = push_len;
        wptr_d        = wptr_q + 2'd1;
      end
      if (dack_v) begin
        if (d_last) begin
          dcnt_d = 4'd0;
          dptr_d = dptr_q + 2'd1;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      if (ack_v) begin
        if (a_last) begin
          acnt_d = 4'd0;
          aptr_d = aptr_q + 2'd1;
        end else begin
          acnt_d = acnt_q + 4'd1;
        end
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 3'd1;
        2'b01:   cnt_d = cnt_q - 3'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q  <= 1'b0;
      last_q <= 1'b1;
      lock_q <= 1'b0;
      own_q  <= '0;
      len_q  <= '0;
      wptr_q <= 2'd0;
      dptr_q <= 2'd0;
      aptr_q <= 2'd0;
      dcnt_q <= 4'd0;
      acnt_q <= 4'd0;
      cnt_q  <= 3'd0;
    end else begin
      sel_q  <= sel_d;
      last_q <= last_d;
      lock_q <= lock_d;
      own_q  <= own_d;
      len_q  <= len_d;
      wptr_q <= wptr_d;
      dptr_q <= dptr_d;
      aptr_q <= aptr_d;
      dcnt_q <= dcnt_d;
      acnt_q <= acnt_d;
      cnt_q  <= cnt_d;
    end
  end

  // A BIU response with nothing outstanding is a protocol error upstream.
  a_rsp_outstanding: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (biu_d_ack_i || biu_ack_i || biu_err_i) |-> !fifo_empty);

endmodule

// File: tb/tb_biu_arbiter2.sv
// Directed bench for biu_arbiter2: expected response vectors are queued per cycle and
// checked by an independent negedge monitor.
module tb_biu_arbiter2;
  localparam logic [7:0] SA0 = 8'h01, SA1 = 8'h02, DA0 = 8'h04, DA1 = 8'h08;
  localparam logic [7:0] AK0 = 8'h10, AK1 = 8'h20, ER0 = 8'h40, ER1 = 8'h80;

  logic HRESETn, HCLK;
  logic p0_stb_i, p0_lock_i, p0_we_i, p1_stb_i, p1_lock_i, p1_we_i;
  logic [31:0] p0_adri_i, p0_d_i, p1_adri_i, p1_d_i;
  logic [2:0]  p0_size_i, p0_type_i, p0_prot_i, p1_size_i, p1_type_i, p1_prot_i;
  logic p0_stb_ack_o, p0_d_ack_o, p0_ack_o, p0_err_o;
  logic p1_stb_ack_o, p1_d_ack_o, p1_ack_o, p1_err_o;
  logic [31:0] p0_q_o, p0_adro_o, p1_q_o, p1_adro_o;
  logic biu_stb_o, biu_lock_o, biu_we_o;
  logic [31:0] biu_adri_o, biu_d_o, biu_q_i, biu_adro_i;
  logic [2:0]  biu_size_o, biu_type_o, biu_prot_o;
  logic biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i;

  typedef struct packed {
    logic [7:0]  v;
    logic [31:0] q;
  } ev_t;
  ev_t sbq[$];
  int total = 0;
  int bad   = 0;

  biu_arbiter2 #(.DATA_SIZE(32), .ADDR_SIZE(32)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .p0_stb_i(p0_stb_i), .p0_adri_i(p0_adri_i), .p0_size_i(p0_size_i), .p0_type_i(p0_type_i),
    .p0_prot_i(p0_prot_i), .p0_lock_i(p0_lock_i), .p0_we_i(p0_we_i), .p0_d_i(p0_d_i),
    .p0_stb_ack_o(p0_stb_ack_o), .p0_d_ack_o(p0_d_ack_o), .p0_ack_o(p0_ack_o),
    .p0_err_o(p0_err_o), .p0_q_o(p0_q_o), .p0_adro_o(p0_adro_o),
    .p1_stb_i(p1_stb_i), .p1_adri_i(p1_adri_i), .p1_size_i(p1_size_i), .p1_type_i(p1_type_i),
    .p1_prot_i(p1_prot_i), .p1_lock_i(p1_lock_i), .p1_we_i(p1_we_i), .p1_d_i(p1_d_i),
    .p1_stb_ack_o(p1_stb_ack_o), .p1_d_ack_o(p1_d_ack_o), .p1_ack_o(p1_ack_o),
    .p1_err_o(p1_err_o), .p1_q_o(p1_q_o), .p1_adro_o(p1_adro_o),
    .biu_stb_o(biu_stb_o), .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o),
    .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o),
    .biu_we_o(biu_we_o), .biu_d_o(biu_d_o),
    .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i), .biu_ack_i(biu_ack_i),
    .biu_err_i(biu_err_i), .biu_q_i(biu_q_i), .biu_adro_i(biu_adro_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue this cycle's expected response vector, then advance to just after the next edge.
  task automatic tick(input logic [7:0] v, input logic [31:0] q);
    biu_q_i    = q;
    biu_adro_i = ~q;
    if (v != 8'h00) sbq.push_back('{v: v, q: q});
    @(negedge HCLK);
    @(posedge HCLK);
    #1;
    biu_stb_ack_i = 1'b0;
    biu_d_ack_i   = 1'b0;
    biu_ack_i     = 1'b0;
    biu_err_i     = 1'b0;
  endtask

  task automatic clear_ports();
    p0_stb_i = 0; p0_adri_i = 0; p0_size_i = 3'd2; p0_type_i = 0; p0_prot_i = 0;
    p0_lock_i = 0; p0_we_i = 0; p0_d_i = 0;
    p1_stb_i = 0; p1_adri_i = 0; p1_size_i = 3'd2; p1_type_i = 0; p1_prot_i = 0;
    p1_lock_i = 0; p1_we_i = 0; p1_d_i = 0;
    biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_ack_i = 0; biu_err_i = 0;
  endtask

  always @(negedge HCLK) begin
    logic [7:0]  vec;
    logic [31:0] aq, aa, eq, ea;
    ev_t e;
    vec = {p1_err_o, p0_err_o, p1_ack_o, p0_ack_o, p1_d_ack_o, p0_d_ack_o, p1_stb_ack_o, p0_stb_ack_o};
    if (vec != 8'h00) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got %02h expected none", vec);
      end else begin
        e  = sbq.pop_front();
        aq = p0_ack_o ? p0_q_o : (p1_ack_o ? p1_q_o : 32'h0);
        aa = p0_ack_o ? p0_adro_o : (p1_ack_o ? p1_adro_o : 32'h0);
        eq = (e.v[5] | e.v[4]) ? e.q : 32'h0;
        ea = (e.v[5] | e.v[4]) ? ~e.q : 32'h0;
        if (vec !== e.v || aq !== eq || aa !== ea) begin
          bad++;
          $display("FAIL rsp_route: got vec=%02h q=%0h adro=%0h expected vec=%02h q=%0h adro=%0h",
                   vec, aq, aa, e.v, eq, ea);
        end
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    clear_ports();
    p1_stb_i = 1; biu_stb_ack_i = 1;
    @(posedge HCLK); #1;
    chk("rst_biu_stb", {31'd0, biu_stb_o}, 32'd0);
    chk("rst_stb_ack", {30'd0, p1_stb_ack_o, p0_stb_ack_o}, 32'd0);
    clear_ports();
    tick(8'h00, 32'h0);
    HRESETn = 1'b1;

    // Single read on p0
    p0_stb_i = 1; p0_adri_i = 32'h100; biu_stb_ack_i = 1; #1;
    chk("t1_stb", {31'd0, biu_stb_o}, 32'd1);
    chk("t1_adr", biu_adri_o, 32'h100);
    tick(SA0, 32'h0);
    p0_stb_i = 0; biu_d_ack_i = 1;
    tick(DA0, 32'h0);
    biu_ack_i = 1;
    tick(AK0, 32'hDEADBEEF);
    tick(8'h00, 32'h0);

    HRESETn = 1'b0; #1; HRESETn = 1'b1;

    // Contention: grants must alternate starting with p0, then the FIFO fills
    p0_stb_i = 1; p0_adri_i = 32'h200; p1_stb_i = 1; p1_adri_i = 32'h300;
    for (int i = 0; i < 4; i++) begin
      biu_stb_ack_i = 1; #1;
      chk("t2_grant", biu_adri_o, (i % 2) ? 32'h300 : 32'h200);
      tick((i % 2) ? SA1 : SA0, 32'h0);
    end
    #1;
    chk("t2_full_mask", {31'd0, biu_stb_o}, 32'd0);
    tick(8'h00, 32'h0);
    p0_stb_i = 0; p1_stb_i = 0;
    for (int i = 0; i < 4; i++) begin
      biu_d_ack_i = 1; biu_ack_i = 1;
      tick((i % 2) ? (DA1 | AK1) : (DA0 | AK0), 32'h10 + i);
    end

    // Lock hold: p1 waits three cycles for its acknowledge while p0 also requests
    p1_stb_i = 1; p1_adri_i = 32'h400; #1;
    chk("t3_lock0", biu_adri_o, 32'h400);
    tick(8'h00, 32'h0);
    p0_stb_i = 1; p0_adri_i = 32'h500;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_lock_hold", biu_adri_o, 32'h400);
      tick(8'h00, 32'h0);
    end
    biu_stb_ack_i = 1; #1;
    chk("t3_ack_adr", biu_adri_o, 32'h400);
    tick(SA1, 32'h0);
    p1_adri_i = 32'h404; biu_stb_ack_i = 1; #1;
    chk("t3_p0_next", biu_adri_o, 32'h500);
    tick(SA0, 32'h0);
    p0_stb_i = 0; p1_stb_i = 0;
    biu_d_ack_i = 1; biu_ack_i = 1;
    tick(DA1 | AK1, 32'h30);
    biu_d_ack_i = 1; biu_ack_i = 1;
    tick(DA0 | AK0, 32'h31);

    // Burst overlap: p0 INCR4 write, then p1 SINGLE write pipelined behind it
    p0_stb_i = 1; p0_adri_i = 32'h600; p0_type_i = 3'd3; p0_we_i = 1; p0_d_i = 32'hA0;
    p1_d_i = 32'hB0; biu_stb_ack_i = 1;
    tick(SA0, 32'h0);
    p0_stb_i = 0; p1_stb_i = 1; p1_adri_i = 32'h700; p1_type_i = 3'd0; p1_we_i = 1;
    biu_stb_ack_i = 1; biu_d_ack_i = 1; #1;
    chk("t4_d_beat1", biu_d_o, 32'hA0);
    tick(SA1 | DA0, 32'h0);
    p1_stb_i = 0;
    for (int i = 0; i < 3; i++) begin
      biu_d_ack_i = 1; biu_ack_i = 1; #1;
      chk("t4_d_p0", biu_d_o, 32'hA0);
      tick(DA0 | AK0, 32'h40 + i);
    end
    biu_d_ack_i = 1; biu_ack_i = 1; #1;
    chk("t4_d_switch", biu_d_o, 32'hB0);
    tick(DA1 | AK0, 32'h43);
    biu_ack_i = 1;
    tick(AK1, 32'h44);

    // Error abort on a p1 WRAP8; same-cycle d_ack/ack must be dropped
    p1_stb_i = 1; p1_adri_i = 32'h800; p1_type_i = 3'd4; p1_we_i = 0; biu_stb_ack_i = 1;
    tick(SA1, 32'h0);
    p1_stb_i = 0;
    for (int i = 0; i < 2; i++) begin
      biu_d_ack_i = 1; biu_ack_i = 1;
      tick(DA1 | AK1, 32'h50 + i);
    end
    biu_err_i = 1; biu_d_ack_i = 1; biu_ack_i = 1;
    tick(ER1, 32'h0);
    p0_stb_i = 1; p0_adri_i = 32'h900; p0_type_i = 3'd0; p0_we_i = 0; biu_stb_ack_i = 1;
    tick(SA0, 32'h0);
    p0_stb_i = 0; biu_d_ack_i = 1; biu_ack_i = 1;
    tick(DA0 | AK0, 32'h60);

    // Fill the FIFO with four SINGLEs, then reset mid-stream
    p0_stb_i = 1;
    for (int i = 0; i < 4; i++) begin
      p0_adri_i = 32'hA00 + 32'(i * 4); biu_stb_ack_i = 1;
      tick(SA0, 32'h0);
    end
    #1;
    chk("t6_full", {31'd0, biu_stb_o}, 32'd0);
    tick(8'h00, 32'h0);
    p1_stb_i = 1; biu_stb_ack_i = 1; biu_d_ack_i = 1; biu_ack_i = 1;
    HRESETn = 1'b0; #1;
    chk("t6_rst_stb", {31'd0, biu_stb_o}, 32'd0);
    chk("t6_rst_outs", {24'd0, p1_err_o, p0_err_o, p1_ack_o, p0_ack_o,
                        p1_d_ack_o, p0_d_ack_o, p1_stb_ack_o, p0_stb_ack_o}, 32'd0);
    tick(8'h00, 32'h0);
    HRESETn = 1'b1;
    p0_adri_i = 32'hB00; p1_adri_i = 32'hC00; biu_stb_ack_i = 1; #1;
    chk("t6_last_after_rst", biu_adri_o, 32'hB00);
    chk("t6_stb_after_rst", {31'd0, biu_stb_o}, 32'd1);
    tick(SA0, 32'h0);
    p0_stb_i = 0; p1_stb_i = 0; biu_d_ack_i = 1; biu_ack_i = 1;
    tick(DA0 | AK0, 32'h70);

    tick(8'h00, 32'h0);
    tick(8'h00, 32'h0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/biu_arbiter2.md
# biu_arbiter2

Two-port arbiter sharing one bus interface unit between the instruction-fetch and data-memory requesters of the core. It sits between the core's two memory ports and the AHB3-Lite bus interface unit. Each strobe handshake is granted to one port by round-robin. A 4-entry owner FIFO routes the pipelined per-beat data-acknowledge, acknowledge and error responses back to the port that issued each transfer.

## Interface
**Parameters**
- `DATA_SIZE`, default 32: data width.
- `ADDR_SIZE`, default `DATA_SIZE`: address width.

**Ports** (`px_` = `p0_` data port / `p1_` instruction port; each port has an identical set)
- `HRESETn` in, 1: reset, asynchronous, active-low.
- `HCLK` in, 1: single clock; all state rises on its positive edge.
- `px_stb_i` in, 1: request strobe; held with all `px_*_i` until `px_stb_ack_o`.
- `px_adri_i` in, `ADDR_SIZE`: request address.
- `px_size_i` in, `biu_size_t`: transfer size.
- `px_type_i` in, `biu_type_t`: burst type.
- `px_prot_i` in, `biu_prot_t`: protection.
- `px_lock_i` in, 1: lock.
- `px_we_i` in, 1: write enable.
- `px_d_i` in, `DATA_SIZE`: write data.
- `px_stb_ack_o` out, 1: strobe accepted.
- `px_d_ack_o` out, 1: send next write data.
- `px_ack_o` out, 1: beat complete.
- `px_err_o` out, 1: transfer error.
- `px_q_o` out, `DATA_SIZE`: read data.
- `px_adro_o` out, `ADDR_SIZE`: data-phase address.
- `biu_stb_o`, `biu_adri_o`, `biu_size_o`, `biu_type_o`, `biu_prot_o`, `biu_lock_o`, `biu_we_o`, `biu_d_o` out: muxed request toward the BIU.
- `biu_stb_ack_i`, `biu_d_ack_i`, `biu_ack_i`, `biu_err_i` in, 1 each: BIU responses.
- `biu_q_i` in, `DATA_SIZE`: BIU read data.
- `biu_adro_i` in, `ADDR_SIZE`: BIU data-phase address.

## Operation
- **Beat length** `len(type)`:
  - SINGLE or INCR → 1
  - WRAP4 or INCR4 → 4
  - WRAP8 or INCR8 → 8
  - WRAP16 or INCR16 → 16
- **Selection register `sel`**, 1 bit.
  - `sel` is free when `lock=0`.
  - While free, the combinational choice is:
    - only one port requesting → that port;
    - both ports requesting → the port ≠ `last`;
    - no port requesting → hold `sel`.
- **Lock flag.**
  - Set when `biu_stb_o=1` and `biu_stb_ack_i=0`; `sel` is then frozen.
  - Cleared on `biu_stb_ack_i`. A requester's strobe is never switched away before it is acknowledged.
- **Request muxing.**
  - All `biu_*_o` request signals = the selected port's inputs.
  - `biu_stb_o` = selected `px_stb_i` & ~`fifo_full`.
  - `biu_d_o` is taken from the port at `dptr` (the d_ack owner), not from `sel`.
- **Strobe acknowledge.** `px_stb_ack_o` = `biu_stb_ack_i` & (`sel`==x).
- **On `biu_stb_ack_i`:**
  - push {owner=`sel`, beats=`len(type)`} into the owner FIFO;
  - `last` ← `sel`.
- **Owner FIFO.** 4 entries, with two read pointers:
  - `dptr`/`dcnt` for d_ack;
  - `aptr`/`acnt` for ack.
- **On `biu_d_ack_i`:**
  - `px_d_ack_o` asserts for owner[`dptr`];
  - `dcnt`++; when `dcnt`==beats−1, `dcnt` ← 0 and `dptr` advances.
- **On `biu_ack_i`:**
  - `px_ack_o` asserts for owner[`aptr`];
  - `acnt`++; on the last beat the entry pops and `aptr` advances.
- **On `biu_err_i`:**
  - `px_err_o` asserts for owner[`aptr`];
  - the FIFO flushes: all pointers and counts are cleared;
  - any `biu_d_ack_i` or `biu_ack_i` in the same cycle is dropped.
- **Broadcast outputs.** `px_q_o` = `biu_q_i` and `px_adro_o` = `biu_adro_i` go to both ports; qualify them with `px_ack_o`.
- **Response with empty FIFO.** A `biu_d_ack_i`, `biu_ack_i` or `biu_err_i` with the FIFO empty is ignored: no port output asserts. Assertion error in simulation.
- **Same-cycle events.** A push and the ack-pop in the same cycle are both performed; the occupancy count is unchanged.

## Timing
- **Reset values:**
  - `sel`=0, `last`=1, so p0 wins the first contention;
  - lock=0, FIFO empty, all pointers and counts 0;
  - all `px_*_o` handshake outputs 0;
  - `biu_stb_o`=0.
- **Latency.**
  - Request muxing and response routing are combinational: zero-cycle latency through the arbiter.
  - Only `sel`, `last`, lock and the FIFO are registered.
- **FIFO full** (4 entries): `biu_stb_o` is masked. `sel` stays free unless lock is already set.
- **Reset mid-burst:** all state returns to reset values immediately; outstanding responses are discarded.

## Test plan
- **Single request.** p0 SINGLE read at 0x100; BIU stb_ack in cycle 1.
  - Required: `p0_stb_ack_o` in cycle 1.
  - Required: `p0_d_ack_o`, then `p0_ack_o`, each with the BIU's response; p1 outputs stay 0 throughout.
- **Contention.** Both ports request SINGLE continuously.
  - Required grants after reset: p0, p1, p0, p1.
  - Required: each ack routes to the issuing port in order.
- **Lock hold.** p1 strobes; the BIU withholds stb_ack for 3 cycles while p0 asserts from cycle 1.
  - Required: `biu_adri_o` stays at p1's address until the ack.
  - Required: p0 is granted next.
- **Burst overlap.** p0 INCR4 then p1 SINGLE, pipelined.
  - Required: 4 `p0_ack_o`, then 1 `p1_ack_o`.
  - Required: `biu_d_o` switches from `p0_d_i` to `p1_d_i` on the fifth d_ack.
- **Error abort.** p1 WRAP8; `biu_err_i` after the 2nd ack.
  - Required: `p1_err_o` for 1 cycle.
  - Required: FIFO empty the next cycle; a later p0 SINGLE is acked normally.
- **Full and reset.** Four SINGLE strobes are acked with no acks returned.
  - Required: `biu_stb_o`=0 on the 5th request.
  - Then assert `HRESETn`=0 mid-stream. Required: all outputs 0 and `last`=1.
